// File: rtl/imu_pkg.sv
// Shared definitions for the IMU accelerometer datapath.
//   AXIS_W   : width of one signed axis sample
//   FRAME_W  : width of one SPI reader burst {X, Y, Z}
//   *_LSB    : bit offsets of each axis within the frame
//   state_t  : filter FSM encoding
package imu_pkg;

    localparam int AXIS_W  = 16;
    localparam int FRAME_W = 48;

    localparam int X_LSB = 32;
    localparam int Y_LSB = 16;
    localparam int Z_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_UPD_X,
        ST_UPD_Y,
        ST_UPD_Z,
        ST_DONE
    } state_t;

endpackage

// File: rtl/imu_accel_filter_if.sv
// Bundle between the SPI reader side and the accelerometer filter.
//   ncs, raw_data          : reader chip select and latched 48-bit burst
//   raw_x/y/z, avg_x/y/z   : latest sample and windowed average per axis
//   avg_valid              : one-cycle pulse when raw_*/avg_* update
//   primed, overrun        : sticky status flags
// master = reader/consumer side, slave = filter.
interface imu_accel_filter_if #(
    parameter int AXIS_W = imu_pkg::AXIS_W
);
    logic                       ncs;
    logic [imu_pkg::FRAME_W-1:0] raw_data;
    logic signed [AXIS_W-1:0]   raw_x;
    logic signed [AXIS_W-1:0]   raw_y;
    logic signed [AXIS_W-1:0]   raw_z;
    logic signed [AXIS_W-1:0]   avg_x;
    logic signed [AXIS_W-1:0]   avg_y;
    logic signed [AXIS_W-1:0]   avg_z;
    logic                       avg_valid;
    logic                       primed;
    logic                       overrun;

    modport master (
        output ncs, raw_data,
        input  raw_x, raw_y, raw_z, avg_x, avg_y, avg_z, avg_valid, primed, overrun
    );

    modport slave (
        input  ncs, raw_data,
        output raw_x, raw_y, raw_z, avg_x, avg_y, avg_z, avg_valid, primed, overrun
    );
endinterface

// File: rtl/imu_accel_filter_sync_edge.sv
// Two-flop synchronizer followed by a previous-value flop and rising-edge
// detector. All flops reset to RESET_VAL so a line already at that level
// when reset releases produces no edge.
//   clk, reset : clock, asynchronous active-high reset
//   din        : asynchronous input
//   rise       : high for one cycle after a synchronized 0->1 transition
module sync_edge #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise
);
    logic s1, s2, s3;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= RESET_VAL;
            s2 <= RESET_VAL;
            s3 <= RESET_VAL;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;
endmodule

// File: rtl/imu_accel_filter.sv
// Accelerometer frame capture and per-axis moving average.
// A rising edge on the reader's ncs marks a complete 48-bit burst; the frame
// is latched, split into signed X/Y/Z, and each axis runs a 2^LOG_DEPTH
// window average held as a running sum over a circular history buffer.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : slave side of imu_accel_filter_if (ncs/raw_data in,
//                raw_*/avg_*/avg_valid/primed/overrun out)
module imu_accel_filter #(
    parameter int LOG_DEPTH = 3,
    parameter int AXIS_W    = imu_pkg::AXIS_W
) (
    input  logic               clk,
    input  logic               reset,
    imu_accel_filter_if.slave  bus
);
    import imu_pkg::*;

    localparam int DEPTH = 1 << LOG_DEPTH;
    localparam int SUM_W = AXIS_W + LOG_DEPTH;
    localparam logic [LOG_DEPTH:0] FULL = (LOG_DEPTH + 1)'(DEPTH);

    typedef logic signed [AXIS_W-1:0] sample_t;
    typedef logic signed [SUM_W-1:0]  sum_t;

    state_t state, next_state;
    logic   frame_edge;

    sample_t new_x, new_y, new_z;
    sum_t    sum_x, sum_y, sum_z;
    sample_t hist_x [DEPTH];
    sample_t hist_y [DEPTH];
    sample_t hist_z [DEPTH];

    logic [LOG_DEPTH-1:0] wr_ptr;
    logic [LOG_DEPTH:0]   fill_cnt;

    sample_t raw_x_r, raw_y_r, raw_z_r;
    sample_t avg_x_r, avg_y_r, avg_z_r;
    logic    avg_valid_r, primed_r, overrun_r;

    sync_edge #(.RESET_VAL(1'b1)) u_ncs_edge (
        .clk   (clk),
        .reset (reset),
        .din   (bus.ncs),
        .rise  (frame_edge)
    );

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (frame_edge) next_state = ST_LOAD;
            ST_LOAD:  next_state = ST_UPD_X;
            ST_UPD_X: next_state = ST_UPD_Y;
            ST_UPD_Y: next_state = ST_UPD_Z;
            ST_UPD_Z: next_state = ST_DONE;
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            new_x       <= '0;
            new_y       <= '0;
            new_z       <= '0;
            sum_x       <= '0;
            sum_y       <= '0;
            sum_z       <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                hist_x[i] <= '0;
                hist_y[i] <= '0;
                hist_z[i] <= '0;
            end
            wr_ptr      <= '0;
            fill_cnt    <= '0;
            raw_x_r     <= '0;
            raw_y_r     <= '0;
            raw_z_r     <= '0;
            avg_x_r     <= '0;
            avg_y_r     <= '0;
            avg_z_r     <= '0;
            avg_valid_r <= 1'b0;
            primed_r    <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            state       <= next_state;
            avg_valid_r <= 1'b0;

            // Frames arriving mid-update are dropped rather than queued.
            if (frame_edge && state != ST_IDLE)
                overrun_r <= 1'b1;

            case (state)
                ST_LOAD: begin
                    new_x <= bus.raw_data[X_LSB +: AXIS_W];
                    new_y <= bus.raw_data[Y_LSB +: AXIS_W];
                    new_z <= bus.raw_data[Z_LSB +: AXIS_W];
                end
                // Oldest sample is read and evicted in the same cycle it is
                // overwritten, so the sum always spans exactly DEPTH entries.
                ST_UPD_X: begin
                    sum_x          <= sum_x + sum_t'(new_x) - sum_t'(hist_x[wr_ptr]);
                    hist_x[wr_ptr] <= new_x;
                end
                ST_UPD_Y: begin
                    sum_y          <= sum_y + sum_t'(new_y) - sum_t'(hist_y[wr_ptr]);
                    hist_y[wr_ptr] <= new_y;
                end
                ST_UPD_Z: begin
                    sum_z          <= sum_z + sum_t'(new_z) - sum_t'(hist_z[wr_ptr]);
                    hist_z[wr_ptr] <= new_z;
                end
                ST_DONE: begin
                    raw_x_r     <= new_x;
                    raw_y_r     <= new_y;
                    raw_z_r     <= new_z;
                    // Arithmetic shift floors toward -inf.
                    avg_x_r     <= sample_t'(sum_x >>> LOG_DEPTH);
                    avg_y_r     <= sample_t'(sum_y >>> LOG_DEPTH);
                    avg_z_r     <= sample_t'(sum_z >>> LOG_DEPTH);
                    avg_valid_r <= 1'b1;
                    wr_ptr      <= wr_ptr + 1'b1;
                    if (fill_cnt != FULL)
                        fill_cnt <= fill_cnt + 1'b1;
                    if (fill_cnt >= FULL - 1'b1)
                        primed_r <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.raw_x     = raw_x_r;
    assign bus.raw_y     = raw_y_r;
    assign bus.raw_z     = raw_z_r;
    assign bus.avg_x     = avg_x_r;
    assign bus.avg_y     = avg_y_r;
    assign bus.avg_z     = avg_z_r;
    assign bus.avg_valid = avg_valid_r;
    assign bus.primed    = primed_r;
    assign bus.overrun   = overrun_r;
endmodule

// File: tb/tb_imu_accel_filter.sv
// Scoreboard bench for imu_accel_filter with LOG_DEPTH=2.
// Stimulus pushes hand-computed expectations; a monitor pops one per
// avg_valid pulse and checks timing and values.
module tb_imu_accel_filter;

    typedef struct {
        longint cyc;
        longint rx, ry, rz, ax, ay, az;
        longint pr;
    } exp_t;

    logic   clk;
    logic   rst;
    longint cyc;
    int     checks;
    int     failures;
    int     n_pushed;
    int     n_seen;
    exp_t   q[$];
    exp_t   mon_e;

    imu_accel_filter_if #(.AXIS_W(16)) bus ();

    imu_accel_filter #(.LOG_DEPTH(2), .AXIS_W(16)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_raw_x"}, bus.raw_x, 0);
        chk({tag, "_raw_y"}, bus.raw_y, 0);
        chk({tag, "_raw_z"}, bus.raw_z, 0);
        chk({tag, "_avg_x"}, bus.avg_x, 0);
        chk({tag, "_avg_y"}, bus.avg_y, 0);
        chk({tag, "_avg_z"}, bus.avg_z, 0);
        chk({tag, "_avg_valid"}, longint'(bus.avg_valid), 0);
        chk({tag, "_primed"}, longint'(bus.primed), 0);
        chk({tag, "_overrun"}, longint'(bus.overrun), 0);
    endtask

    task automatic push_exp(input longint rx, ry, rz, ax, ay, az, pr);
        exp_t e;
        // ncs set after edge cyc, so the sampling edge k is cyc+1 and the
        // update lands on k+7.
        e.cyc = cyc + 8;
        e.rx = rx; e.ry = ry; e.rz = rz;
        e.ax = ax; e.ay = ay; e.az = az;
        e.pr = pr;
        q.push_back(e);
        n_pushed++;
    endtask

    task automatic send_frame(input logic [47:0] d,
                              input longint rx, ry, rz, ax, ay, az, pr);
        @(negedge clk);
        bus.raw_data = d;
        bus.ncs      = 1'b0;
        repeat (3) @(negedge clk);
        bus.ncs = 1'b1;
        push_exp(rx, ry, rz, ax, ay, az, pr);
        repeat (12) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Monitor: every avg_valid must match the oldest outstanding expectation.
    always @(posedge clk) begin
        #1;
        if (!rst && bus.avg_valid) begin
            n_seen++;
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_avg_valid actual=1 expected=0 (cycle %0d)", cyc);
            end else begin
                mon_e = q.pop_front();
                chk("valid_cycle", cyc, mon_e.cyc);
                chk("raw_x", bus.raw_x, mon_e.rx);
                chk("raw_y", bus.raw_y, mon_e.ry);
                chk("raw_z", bus.raw_z, mon_e.rz);
                chk("avg_x", bus.avg_x, mon_e.ax);
                chk("avg_y", bus.avg_y, mon_e.ay);
                chk("avg_z", bus.avg_z, mon_e.az);
                chk("primed", longint'(bus.primed), mon_e.pr);
            end
        end
    end

    localparam logic [47:0] FRAME_A = 48'h0100_FF00_4000;
    localparam logic [47:0] FRAME_0 = 48'h0;
    localparam logic [47:0] FRAME_Y = 48'h0000_FFFF_0000;
    localparam logic [47:0] FRAME_B = 48'h0008_0004_FFFC;

    initial begin
        cyc      = 0;
        checks   = 0;
        failures = 0;
        n_pushed = 0;
        n_seen   = 0;
        rst      = 1'b1;
        bus.ncs  = 1'b1;
        bus.raw_data = '0;

        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        rst = 1'b0;
        // ncs high through reset release: no frame may be reported.
        repeat (12) @(negedge clk);
        chk("no_valid_after_release", n_seen, 0);

        // Ramp-up with a constant frame, priming on the fourth.
        send_frame(FRAME_A, 256, -256, 16384,  64,  -64,  4096, 0);
        send_frame(FRAME_A, 256, -256, 16384, 128, -128,  8192, 0);
        send_frame(FRAME_A, 256, -256, 16384, 192, -192, 12288, 0);
        send_frame(FRAME_A, 256, -256, 16384, 256, -256, 16384, 1);
        // Zero frames evict the old samples one by one.
        send_frame(FRAME_0, 0, 0, 0, 192, -192, 12288, 1);
        send_frame(FRAME_0, 0, 0, 0, 128, -128,  8192, 1);
        send_frame(FRAME_0, 0, 0, 0,  64,  -64,  4096, 1);
        send_frame(FRAME_0, 0, 0, 0,   0,    0,     0, 1);
        chk("overrun_normal_framing", longint'(bus.overrun), 0);

        // Floor rounding of a small negative sum.
        pulse_reset();
        chk_outputs_zero("reset2");
        send_frame(FRAME_Y, 0, -1, 0, 0, -1, 0, 0);

        // Overrun: second rising edge 4 cycles after the first.
        pulse_reset();
        @(negedge clk);
        bus.raw_data = FRAME_B;
        bus.ncs      = 1'b0;
        repeat (3) @(negedge clk);
        bus.ncs = 1'b1;
        push_exp(8, 4, -4, 2, 1, -1, 0);
        repeat (2) @(negedge clk);
        bus.ncs = 1'b0;
        repeat (2) @(negedge clk);
        bus.ncs = 1'b1;
        repeat (20) @(negedge clk);
        chk("overrun_set", longint'(bus.overrun), 1);
        chk("overrun_single_valid", n_seen, n_pushed);
        // Sticky across a later clean frame; window now holds two samples.
        send_frame(FRAME_B, 8, 4, -4, 4, 2, -2, 0);
        chk("overrun_sticky", longint'(bus.overrun), 1);

        // Reset in UPD_Y discards the frame and restarts from scratch.
        pulse_reset();
        send_frame(FRAME_A, 256, -256, 16384, 64, -64, 4096, 0);
        @(negedge clk);
        bus.ncs = 1'b0;
        repeat (3) @(negedge clk);
        bus.ncs = 1'b1;
        // k = edge after this negedge; UPD_Y holds between edges k+4 and k+5.
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk_outputs_zero("reset_midop");
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        send_frame(FRAME_A, 256, -256, 16384, 64, -64, 4096, 0);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);
        chk("valid_count", n_seen, n_pushed);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
